// File: rtl/mlp_engine.sv
// Time-multiplexed fixed-point MLP: one shared MAC walks the weight/bias memory, one weight per clock.
// Latency: strobe in cycle 0, outputs_ready pulses in cycle C+1 where C = sum over layers of N_out*(N_in+1).
// No backpressure: inputs_ready and weight writes are dropped while busy; results hold until the next run ends.

package mlp_engine_pkg;
  typedef enum logic [0:0] {RELU = 1'b0, SIGMOID = 1'b1} activation_t;
endpackage

module mlp_engine
  import mlp_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int NUM_INPUTS = 4,
  parameter int NUM_LAYERS = 2,
  parameter int LAYER_SIZES [NUM_LAYERS] = '{3, 2},
  parameter activation_t LAYER_ACTIVATIONS [NUM_LAYERS] = '{RELU, SIGMOID},
  localparam int NUM_OUTPUTS = LAYER_SIZES[NUM_LAYERS-1],
  localparam int TOTAL_WORDS = total_words_f(),
  localparam int ADDRESS_WIDTH = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1,
  localparam int PREDICTION_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               inputs_ready,
  input  logic signed [DATA_WIDTH-1:0]       inputs [NUM_INPUTS],
  input  logic                               weight_write,
  input  logic        [ADDRESS_WIDTH-1:0]    weight_address,
  input  logic signed [DATA_WIDTH-1:0]       weight_data,
  output logic signed [DATA_WIDTH-1:0]       outputs [NUM_OUTPUTS],
  output logic                               outputs_ready,
  output logic                               busy,
  output logic        [PREDICTION_WIDTH-1:0] prediction
);

  // Total memory words: every neuron owns N_in weights plus one bias.
  function automatic int total_words_f();
    int s;
    int prev;
    s = 0;
    prev = NUM_INPUTS;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      s += LAYER_SIZES[l] * (prev + 1);
      prev = LAYER_SIZES[l];
    end
    return s;
  endfunction

  // Widest fan-in of any layer; sizes the accumulator headroom.
  function automatic int max_in_f();
    int m;
    m = NUM_INPUTS;
    for (int l = 0; l < NUM_LAYERS - 1; l++)
      if (LAYER_SIZES[l] > m) m = LAYER_SIZES[l];
    return m;
  endfunction

  // Widest vector ever held in a ping-pong buffer.
  function automatic int max_dim_f();
    int m;
    m = NUM_INPUTS;
    for (int l = 0; l < NUM_LAYERS; l++)
      if (LAYER_SIZES[l] > m) m = LAYER_SIZES[l];
    return m;
  endfunction

  localparam int MAX_IN  = max_in_f();
  localparam int MAX_DIM = max_dim_f();
  localparam int IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int ACC_W   = 2 * DATA_WIDTH + $clog2(MAX_IN + 1);
  localparam int SUM_W   = ACC_W + 1;
  localparam int DW1     = DATA_WIDTH + 1;

  localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DW1-1:0]        SIG_HALF = DW1'(2 ** (FRAC_BITS - 1));
  localparam logic signed [DW1-1:0]        SIG_ONE  = DW1'(2 ** FRAC_BITS);

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t                      state;
  logic [LAYER_W-1:0]          layer;
  logic [IDX_W-1:0]            neuron;
  logic [IDX_W-1:0]            idx;
  logic [ADDRESS_WIDTH-1:0]    addr;
  logic                        src_sel;
  logic signed [ACC_W-1:0]     acc;
  logic signed [DATA_WIDTH-1:0] buf_a [MAX_DIM];
  logic signed [DATA_WIDTH-1:0] buf_b [MAX_DIM];
  logic signed [DATA_WIDTH-1:0] best_val;
  logic [PREDICTION_WIDTH-1:0] best_idx;
  logic signed [DATA_WIDTH-1:0] mem [TOTAL_WORDS];

  logic [IDX_W-1:0]               last_idx;
  logic [IDX_W-1:0]               last_neuron;
  activation_t                    act;
  logic                           last_layer;
  logic signed [DATA_WIDTH-1:0]   mem_rd;
  logic signed [DATA_WIDTH-1:0]   x_rd;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_W-1:0]        prod_ext;
  logic signed [SUM_W-1:0]        bias_ext;
  logic signed [SUM_W-1:0]        biased;
  logic signed [SUM_W-1:0]        shifted;
  logic signed [DATA_WIDTH-1:0]   sat_val;
  logic signed [DW1-1:0]          sig_tmp;
  logic signed [DATA_WIDTH-1:0]   act_val;
  logic                           is_new_max;

  // Per-layer geometry and activation for the layer currently being evaluated.
  always_comb begin
    int prev;
    prev        = NUM_INPUTS;
    last_idx    = '0;
    last_neuron = '0;
    act         = RELU;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (layer == LAYER_W'(l)) begin
        last_idx    = IDX_W'(prev - 1);
        last_neuron = IDX_W'(LAYER_SIZES[l] - 1);
        act         = LAYER_ACTIVATIONS[l];
      end
      prev = LAYER_SIZES[l];
    end
  end

  assign last_layer = (layer == LAYER_W'(NUM_LAYERS - 1));
  assign mem_rd     = mem[addr];
  assign x_rd       = src_sel ? buf_b[idx] : buf_a[idx];

  // MAC operand, bias fold-in, rescale, saturation and activation.
  always_comb begin
    product  = mem_rd * x_rd;
    prod_ext = {{(ACC_W-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
    bias_ext = {{(SUM_W-DATA_WIDTH){mem_rd[DATA_WIDTH-1]}}, mem_rd};
    biased   = {acc[ACC_W-1], acc} + (bias_ext <<< FRAC_BITS);
    shifted  = biased >>> FRAC_BITS;
    if (shifted > SUM_W'(DATA_MAX))
      sat_val = DATA_MAX;
    else if (shifted < SUM_W'(DATA_MIN))
      sat_val = DATA_MIN;
    else
      sat_val = shifted[DATA_WIDTH-1:0];
    sig_tmp = ($signed({sat_val[DATA_WIDTH-1], sat_val}) >>> 2) + SIG_HALF;
    if (act == SIGMOID) begin
      if (sig_tmp[DW1-1])
        act_val = '0;
      else if (sig_tmp > SIG_ONE)
        act_val = SIG_ONE[DATA_WIDTH-1:0];
      else
        act_val = sig_tmp[DATA_WIDTH-1:0];
    end else begin
      act_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
    end
    // Strictly-greater keeps the lowest index on ties.
    is_new_max = (neuron == '0) || (act_val > best_val);
  end

  // Weight/bias memory: idle-only writes, out-of-range addresses dropped, not cleared by reset.
  always_ff @(posedge clock) begin
    if (weight_write && !busy && (32'(weight_address) < TOTAL_WORDS))
      mem[weight_address] <= weight_data;
  end

  // Sequencer: walks weights in memory order, one address per compute cycle, with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      layer         <= '0;
      neuron        <= '0;
      idx           <= '0;
      addr          <= '0;
      src_sel       <= 1'b0;
      acc           <= '0;
      best_val      <= '0;
      best_idx      <= '0;
      outputs_ready <= 1'b0;
      busy          <= 1'b0;
      prediction    <= '0;
      for (int k = 0; k < MAX_DIM; k++) begin
        buf_a[k] <= '0;
        buf_b[k] <= '0;
      end
      for (int j = 0; j < NUM_OUTPUTS; j++)
        outputs[j] <= '0;
    end else begin
      outputs_ready <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (inputs_ready) begin
            for (int i = 0; i < NUM_INPUTS; i++)
              buf_a[i] <= inputs[i];
            state   <= MAC;
            layer   <= '0;
            neuron  <= '0;
            idx     <= '0;
            addr    <= '0;
            src_sel <= 1'b0;
            busy    <= 1'b1;
          end
        end
        MAC: begin
          acc  <= (idx == '0) ? prod_ext : acc + prod_ext;
          addr <= addr + 1'b1;
          if (idx == last_idx)
            state <= WRITE;
          else
            idx <= idx + 1'b1;
        end
        WRITE: begin
          addr <= addr + 1'b1;
          idx  <= '0;
          if (src_sel)
            buf_a[neuron] <= act_val;
          else
            buf_b[neuron] <= act_val;
          if (last_layer && is_new_max) begin
            best_val <= act_val;
            best_idx <= PREDICTION_WIDTH'(neuron);
          end
          if (neuron == last_neuron) begin
            neuron <= '0;
            if (last_layer) begin
              state         <= DONE;
              busy          <= 1'b0;
              outputs_ready <= 1'b1;
              prediction    <= is_new_max ? PREDICTION_WIDTH'(neuron) : best_idx;
              for (int j = 0; j < NUM_OUTPUTS; j++)
                outputs[j] <= (neuron == IDX_W'(j)) ? act_val : (src_sel ? buf_a[j] : buf_b[j]);
            end else begin
              state   <= MAC;
              layer   <= layer + 1'b1;
              src_sel <= ~src_sel;
            end
          end else begin
            state  <= MAC;
            neuron <= neuron + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_engine.sv
// Self-checking bench for mlp_engine: directed scenarios with literal results plus randomized traffic.
// Latency under test: strobe cycle to outputs_ready is 24 cycles at default geometry.
// A cycle-level reference model tracks busy/ready/outputs; strobes and writes while busy are dropped.

module tb_mlp_engine;

  localparam int C = 23;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  logic               inputs_ready;
  logic signed [15:0] in_vec [4];
  logic               weight_write;
  logic [4:0]         weight_address;
  logic signed [15:0] weight_data;
  logic signed [15:0] out_vec [2];
  logic               outputs_ready;
  logic               busy;
  logic [0:0]         prediction;

  mlp_engine dut (
    .clock          (clock),
    .reset          (reset),
    .inputs_ready   (inputs_ready),
    .inputs         (in_vec),
    .weight_write   (weight_write),
    .weight_address (weight_address),
    .weight_data    (weight_data),
    .outputs        (out_vec),
    .outputs_ready  (outputs_ready),
    .busy           (busy),
    .prediction     (prediction)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int tmem [C];
  int m_outs [2];
  int m_pred;
  bit m_busy;
  bit m_ready;
  int m_left;
  int pend_o [2];
  int pend_p;
  bit model_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Whole-network evaluation straight from the arithmetic rules.
  function automatic void net_eval(input int x [4], output int o [2], output int p);
    int sizes [2];
    int cur [$];
    int nxt [$];
    int base;
    int nin;
    longint acc;
    longint r;
    sizes = '{3, 2};
    cur = {x[0], x[1], x[2], x[3]};
    base = 0;
    for (int l = 0; l < 2; l++) begin
      nin = cur.size();
      nxt = {};
      for (int n = 0; n < sizes[l]; n++) begin
        acc = longint'(tmem[base + n*(nin+1) + nin]) * 256;
        for (int i = 0; i < nin; i++)
          acc += longint'(tmem[base + n*(nin+1) + i]) * longint'(cur[i]);
        r = acc >>> 8;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (l == 0) begin
          if (r < 0) r = 0;
        end else begin
          r = (r >>> 2) + 128;
          if (r < 0) r = 0;
          if (r > 256) r = 256;
        end
        nxt.push_back(int'(r));
      end
      base += sizes[l] * (nin + 1);
      cur = nxt;
    end
    o[0] = cur[0];
    o[1] = cur[1];
    p = (o[1] > o[0]) ? 1 : 0;
  endfunction

  // Reference model: advances expected busy/ready/outputs once per clock.
  always @(posedge clock) begin
    int xv [4];
    cyc = cyc + 1;
    if (reset) begin
      model_on = 1'b1;
      m_busy = 1'b0;
      m_ready = 1'b0;
      m_left = 0;
      m_outs = '{0, 0};
      m_pred = 0;
    end else if (model_on) begin
      m_ready = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_ready = 1'b1;
          m_outs = pend_o;
          m_pred = pend_p;
        end
      end else begin
        if (weight_write && weight_address < C)
          tmem[weight_address] = int'(weight_data);
        if (inputs_ready) begin
          for (int i = 0; i < 4; i++) xv[i] = int'(in_vec[i]);
          net_eval(xv, pend_o, pend_p);
          m_busy = 1'b1;
          m_left = C;
        end
      end
    end
  end

  // Compare process: every cycle after the first reset.
  always @(negedge clock) begin
    if (model_on) begin
      chk("outputs_ready", int'(outputs_ready), int'(m_ready));
      chk("busy", int'(busy), int'(m_busy));
      chk("prediction", int'(prediction), m_pred);
      chk("outputs[0]", int'(out_vec[0]), m_outs[0]);
      chk("outputs[1]", int'(out_vec[1]), m_outs[1]);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    weight_write = 1'b1;
    weight_address = 5'(a);
    weight_data = 16'(d);
    next_cycle();
    weight_write = 1'b0;
  endtask

  task automatic set_inputs(input int a, input int b, input int c, input int d);
    in_vec[0] = 16'(a);
    in_vec[1] = 16'(b);
    in_vec[2] = 16'(c);
    in_vec[3] = 16'(d);
  endtask

  task automatic strobe(input int a, input int b, input int c, input int d, output int s);
    set_inputs(a, b, c, d);
    inputs_ready = 1'b1;
    s = cyc;
    next_cycle();
    inputs_ready = 1'b0;
  endtask

  task automatic wait_ready(input int s, input string tag, input int o0, input int o1, input int p);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clock);
      if (outputs_ready) seen = 1'b1;
    end
    chk({tag, " pulse seen"}, int'(seen), 1);
    if (seen) begin
      chk({tag, " latency"}, cyc - s, 24);
      chk({tag, " out0"}, int'(out_vec[0]), o0);
      chk({tag, " out1"}, int'(out_vec[1]), o1);
      chk({tag, " pred"}, int'(prediction), p);
    end
    next_cycle();
  endtask

  initial begin
    int s;
    int s2;
    int v;
    reset = 1'b1;
    inputs_ready = 1'b0;
    weight_write = 1'b0;
    weight_address = '0;
    weight_data = '0;
    set_inputs(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset ready", int'(outputs_ready), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset pred", int'(prediction), 0);
    chk("reset out0", int'(out_vec[0]), 0);
    next_cycle();

    // All-zero memory.
    for (int a = 0; a < C; a++) write_word(a, 0);
    strobe(256, -512, 128, 768, s);
    wait_ready(s, "zero net", 128, 128, 0);

    // Diagonal layer 0, two pass-through taps in layer 1; ignored strobe/write mid-run.
    write_word(0, 256);
    write_word(6, 256);
    write_word(12, 256);
    write_word(15, 256);
    write_word(21, 256);
    strobe(256, -512, 128, 768, s);
    repeat (4) next_cycle();
    set_inputs(1000, 1000, 1000, 1000);
    inputs_ready = 1'b1;
    weight_write = 1'b1;
    weight_address = 5'd0;
    weight_data = 16'h1234;
    next_cycle();
    inputs_ready = 1'b0;
    weight_write = 1'b0;
    wait_ready(s, "diag", 192, 160, 0);

    // Reset mid-run aborts without a pulse; weights survive.
    strobe(256, -512, 128, 768, s);
    repeat (9) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("abort busy", int'(busy), 0);
    chk("abort ready", int'(outputs_ready), 0);
    chk("abort out0", int'(out_vec[0]), 0);
    chk("abort out1", int'(out_vec[1]), 0);
    next_cycle();
    strobe(256, -512, 128, 768, s2);
    chk("restart offset", s2 - s, 12);
    wait_ready(s2, "after reset", 192, 160, 0);

    // Back-to-back: second strobe coincides with the first pulse.
    strobe(256, -512, 128, 768, s);
    repeat (23) next_cycle();
    set_inputs(-256, 0, 512, 0);
    inputs_ready = 1'b1;
    @(negedge clock);
    chk("b2b first pulse", int'(outputs_ready), 1);
    chk("b2b first latency", cyc - s, 24);
    chk("b2b first out0", int'(out_vec[0]), 192);
    s = cyc;
    next_cycle();
    inputs_ready = 1'b0;
    wait_ready(s, "b2b second", 128, 256, 1);

    // Saturation through layer 0.
    for (int a = 0; a < 15; a++) write_word(a, 32767);
    strobe(32767, 32767, 32767, 32767, s);
    wait_ready(s, "sat high", 256, 256, 0);
    strobe(-32768, -32768, -32768, -32768, s);
    wait_ready(s, "sat low", 128, 128, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      reset = ($urandom_range(0, 399) == 0);
      inputs_ready = !reset && ($urandom_range(0, 5) == 0);
      weight_write = !reset && ($urandom_range(0, 3) == 0);
      weight_address = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 65535));
      else v = int'($urandom_range(0, 1023)) - 512;
      weight_data = 16'(v);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 65535));
        else v = int'($urandom_range(0, 2047)) - 1024;
        in_vec[i] = 16'(v);
      end
      next_cycle();
    end
    reset = 1'b0;
    inputs_ready = 1'b0;
    weight_write = 1'b0;
    repeat (30) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
